// File: rtl/inst_rom_loader.sv
// Instruction ROM for the OpenMIPS fetch port with a big-endian byte-stream loader.
// Define INST_ROM_CHECKSUM_EN to add the ld_sum_o running word checksum.
module inst_rom_loader #(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce_i,
   input  logic [31:0]       addr_i,
   output logic [31:0]       inst_o,
   input  logic              ld_start_i,
   input  logic [ADDR_W:0]   ld_len_i,
   input  logic              ld_valid_i,
   input  logic [7:0]        ld_byte_i,
   output logic              ld_ready_o,
   output logic              ld_busy_o,
   output logic              ld_done_o,
`ifdef INST_ROM_CHECKSUM_EN
   output logic [31:0]       ld_sum_o,
`endif
   output logic              ld_err_o
);

   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state;
   logic [ADDR_W:0]     len;
   logic [ADDR_W-1:0]   wptr;
   logic [1:0]          bcnt;
   logic [23:0]         part;
   logic                ready;
   logic                busy;
   logic                done;
   logic                err;
`ifdef INST_ROM_CHECKSUM_EN
   logic [31:0]         sum;
`endif

   logic [31:0]         mem [0:(1<<ADDR_W)-1];

   logic                len_ok;
   logic                take;
   logic                last_byte;
   logic                last_word;
   logic                wr_en;
   logic [31:0]         word;

   assign len_ok    = (ld_len_i != '0) && (ld_len_i <= MAX_LEN);
   assign take      = (state == S_LOAD) && ready && ld_valid_i;
   assign last_byte = (bcnt == 2'd3);
   assign last_word = ({1'b0, wptr} == (len - 1'b1));
   assign word      = {part, ld_byte_i};
   // A reset coinciding with a fourth byte must not commit the word.
   assign wr_en     = take && last_byte && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         len   <= '0;
         wptr  <= '0;
         bcnt  <= '0;
         part  <= '0;
         ready <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
`ifdef INST_ROM_CHECKSUM_EN
         sum   <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (ld_start_i) begin
                  if (len_ok) begin
                     state <= S_LOAD;
                     len   <= ld_len_i;
                     wptr  <= '0;
                     bcnt  <= '0;
                     part  <= '0;
                     ready <= 1'b1;
                     busy  <= 1'b1;
                     err   <= 1'b0;
`ifdef INST_ROM_CHECKSUM_EN
                     sum   <= '0;
`endif
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (take) begin
                  part <= {part[15:0], ld_byte_i};
                  bcnt <= bcnt + 2'd1;
                  if (last_byte) begin
                     wptr <= wptr + 1'b1;
`ifdef INST_ROM_CHECKSUM_EN
                     sum  <= sum + word;
`endif
                     if (last_word) begin
                        state <= S_DONE;
                        ready <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
               ready <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               ready <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // The array is deliberately never reset so a reset can't wipe a loaded program.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr] <= word;
   end

   assign inst_o = (ce_i && !rst && !busy) ? mem[addr_i[ADDR_W+1:2]] : 32'h0;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

   assign ld_ready_o = ready;
   assign ld_busy_o  = busy;
   assign ld_done_o  = done;
   assign ld_err_o   = err;
`ifdef INST_ROM_CHECKSUM_EN
   assign ld_sum_o   = sum;
`endif

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Instruction-memory responder for the OpenMIPS fetch port, with a byte-stream program loader. It answers the core's combinational fetch handshake: the core drives a chip enable and a byte address, and this block returns a 32-bit instruction. A ready/valid byte loader assembles big-endian words and writes them into the array. While a load is in progress the block reports busy, so the system can hold the core in reset.

## Interface
- ADDR_W, 17, log2 of the array depth in 32-bit words (depth = 2^ADDR_W).
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ce_i  in  1  fetch enable, driven by the core's rom_ce_o.
- addr_i  in  32  fetch byte address, driven by the core's rom_addr_o.
- inst_o  out  32  fetched instruction, drives the core's rom_data_i.
- ld_start_i  in  1  single-cycle request to begin a load at word 0.
- ld_len_i  in  ADDR_W+1  number of words to load; sampled with ld_start_i.
- ld_valid_i  in  1  loader byte valid.
- ld_byte_i  in  8  loader byte.
- ld_ready_o  out  1  block accepts a byte this cycle.
- ld_busy_o  out  1  load in progress.
- ld_done_o  out  1  one-cycle pulse when a load completes.
- ld_err_o  out  1  sticky flag for a rejected start.
- ld_sum_o  out  32  running word checksum; present only with INST_ROM_CHECKSUM_EN.

## Operation
- **Fetch (combinational):**
  - inst_o = mem[addr_i[ADDR_W+1:2]] when ce_i=1, rst=0 and ld_busy_o=0; otherwise 32'h0 (NOP).
  - addr_i[1:0] and bits above ADDR_W+1 are ignored, so addresses wrap modulo the array size.
- **States:** IDLE, LOAD, DONE.
- **IDLE:**
  - ld_start_i=1 with 1 ≤ ld_len_i ≤ 2^ADDR_W → go to LOAD.
    - Latch len; clear write pointer wptr and byte counter bcnt; clear ld_err_o.
    - Clear the checksum (when the feature is compiled in).
  - ld_start_i=1 with any other ld_len_i → set ld_err_o and stay in IDLE.
- **LOAD:**
  - ld_ready_o=1. A byte transfers when ld_valid_i and ld_ready_o are both 1.
  - Bytes are big-endian: the first byte of each word lands in bits 31:24, the fourth in bits 7:0.
  - On the fourth byte, write the assembled word to mem[wptr] and increment wptr; bcnt wraps to 0.
  - If the written word is the last one (wptr == len-1) → go to DONE.
  - ld_start_i is ignored in LOAD.
- **DONE:** ld_done_o=1, ld_ready_o=0, ld_busy_o=1; go to IDLE on the next cycle.
- **ld_busy_o:** 1 in LOAD and DONE, 0 in IDLE.
- **Array:** never cleared. Words outside the loaded range keep their previous contents.
- **Reset mid-load:**
  - State returns to IDLE; wptr, bcnt, the partial word, the checksum and all flags clear.
  - Words already written stay in the array.

## Timing
- **Reset values:** ld_ready_o=0, ld_busy_o=0, ld_done_o=0, ld_err_o=0, ld_sum_o=0; inst_o=0 while rst=1.
- **Fetch latency:** zero cycles (same-cycle data). This matches the core registering rom_data_i in IF/ID on the same edge it registers the PC.
- **Load timeline:**
  - Start sampled in cycle 0; ld_busy_o and ld_ready_o go high in cycle 1.
  - With back-to-back bytes, a load of N words transfers bytes in cycles 1..4N.
  - The final word is written at the end of cycle 4N; ld_done_o is high in cycle 4N+1.
  - ld_busy_o goes low in cycle 4N+2.
- **Throughput:** at most one byte per cycle. Gaps in ld_valid_i stall the load with no loss of state.
- **Write visibility:** a written word is visible to fetch from the cycle after its write. Fetch returns 0 anyway until ld_busy_o falls.

## Configuration
- **INST_ROM_CHECKSUM_EN:**
  - Defined: port ld_sum_o exists. It is cleared on an accepted start and incremented by each written word, modulo 2^32, in the same edge as the array write. It holds its value after DONE until the next accepted start or reset.
  - Undefined: the port and the adder are absent; all other behaviour is identical.

## Test plan
- **Reset, idle fetch:** reset, then fetch with ce_i=1, addr_i=0 on a blank array → inst_o=0; all loader outputs 0.
- **2-word load:**
  - Stimulus: ld_len_i=2, bytes 34 01 00 10 20 42 00 05 back-to-back.
  - Expect: mem[0]=32'h34010010, mem[1]=32'h20420005; ld_done_o high in cycle 9; ld_busy_o low in cycle 10.
  - Expect: fetch addr 0x4 → 32'h20420005; ld_sum_o=32'h54430015.
- **Stalled valid:** same load with ld_valid_i low every other cycle → identical array contents; ld_done_o in cycle 17.
- **Invalid length:** ld_len_i=0 or 2^ADDR_W+1 → ld_err_o=1, ld_busy_o stays 0. A following valid start clears ld_err_o.
- **Reset mid-load:**
  - Stimulus: assert rst after 6 bytes of a 2-word load.
  - Expect: IDLE, ld_busy_o=0, mem[0] retains the written word, mem[1] unchanged.
- **Busy and wrap:** fetch during a load returns 0. Fetch of addr_i=32'h0008_0004 with ADDR_W=17 returns mem[1].
